sp_mash_111: RTL and testbench
==============================

// Module: sp_mash_111
// PURPOSE
//  Third-order SP-MASH 1-1-1 digital delta-sigma modulator (DDSM) for fractional-N division control.
//  Three cascaded error-feedback accumulators (EFMs) with SP carry feedback.
//   - The SP feedback makes the effective modulus 2^WIDTH-SP_A, which breaks short limit cycles and spurs.
//  Noise-cancellation network combines the three carries into a 4-bit signed output: mean = x_i/(2^WIDTH-SP_A).
//  Sits between the frequency-word register and the multi-modulus divider.
// PARAMETERS
//  WIDTH    9  accumulator / input / residue width (bits)
//  OUT_REG  1  1: y_o and e_o registered (+1 cycle latency); 0: driven combinationally from state
//  SP_A     1  SP feedback constant added on carry; valid range 1..2^(WIDTH-1)-1
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst_n  in   1      asynchronous, ACTIVE-HIGH reset (port keeps the codebase name; asserted = 1)
//  x_i    in   WIDTH  unsigned fractional input word, 0..2^WIDTH-1
//  y_o    out  4      signed two's-complement modulator output, range -3..+4
//  e_o    out  WIDTH  stage-3 residue (quantisation error of the last EFM)
// BEHAVIOUR
//  Reset (rst_n=1): all residues r1..r3, carries c1..c3 and the cancellation delay registers clear to 0.
//   Output registers also clear: y_o=0, e_o=0. Clearing is immediate and asynchronous.
//  Reset mid-run has the same effect; the first update after release starts the sequence again from zero.
//  Stage k, each cycle (in1=x_i, in2=r1, in3=r2), using current-cycle residues of the previous stage:
//   s_k = in_k + r_k + SP_A*c_k, computed WIDTH+1 bits wide
//   c_k(next) = (s_k >= 2^WIDTH)
//   r_k(next) = s_k mod 2^WIDTH
//   No saturation: the carry is the only overflow path.
//  Noise cancellation, with d = one-cycle delay:
//   y = c1 + (c2 - d(c2)) + (c3 - 2*d(c3) + d(d(c3)))
//   Width: sign-extend to 4 bits; the result is always in -3..+4, so there is no overflow.
//  e_o = r3.
//  Latency: OUT_REG=0 -> y_o reflects the carries registered on the current edge.
//   OUT_REG=1 -> one additional cycle.
//  x_i=0 from reset: all carries remain 0, so y_o=0 and e_o=0 forever.
//  x_i changes take effect on the next edge; there is no handshake and no enable.
//  Long-run average of y_o equals x_i/(2^WIDTH-SP_A) exactly, since sum(y) = sum(c1) + bounded terms.
// STRUCTURE
//  Package sp_mash_pkg:
//   - localparam Y_W=4
//   - function for the cancellation sum
//   - default SP_A
//  One sub-module sp_efm_stage, instantiated 3x:
//   - ports: clk, rst_n, in[WIDTH-1:0], r_o[WIDTH-1:0], c_o
//   - holds residue and carry registers plus the SP adder
//  Top holds the delay registers for c2 and c3, the cancellation adder and the optional OUT_REG stage.
// TESTING
//  1. Reset: hold rst_n=1 with x_i=16, toggle clk -> y_o=0 and e_o=0 throughout.
//     Assert rst_n between edges -> outputs clear without waiting for a clock.
//  2. x_i=0, 1000 cycles after reset release -> y_o=0 and e_o=0 every cycle.
//  3. x_i=16, WIDTH=9, SP_A=1, OUT_REG=1, 10000 cycles:
//     - y_o always in -3..+4
//     - sum(y_o)/N within 1e-3 of 16/511
//     - first nonzero c1 on the 32nd update
//  4. x_i=511: mean(y_o) within 1e-3 of 511/511=1.0; no value outside -3..+4.
//  5. Latency: same stimulus with OUT_REG=0 and 1 -> identical y_o/e_o sequences, the OUT_REG=1 copy delayed by exactly 1 cycle.
//  6. Reset mid-run at cycle 500, x_i=16 -> after release, the sequence matches cycles 0.. of test 3 bit-exactly.

Source files
------------

// File: rtl/sp_mash_pkg.sv
// SP-MASH 1-1-1 shared definitions: output width, default SP constant
// and the noise-cancellation sum used by the top level.
package sp_mash_pkg;

    localparam int Y_W      = 4;
    localparam int SP_A_DEF = 1;

    // y = c1 + (c2 - d(c2)) + (c3 - 2*d(c3) + d(d(c3)))
    // Evaluated modulo 2^Y_W; the true result is always in -3..+4,
    // so the wrapped two's-complement value is exact.
    function automatic logic signed [Y_W-1:0] cancel_sum(
        input logic c1,
        input logic c2,
        input logic dc2,
        input logic c3,
        input logic dc3,
        input logic ddc3
    );
        logic [Y_W-1:0] t;
        t = Y_W'(c1)
          + Y_W'(c2) - Y_W'(dc2)
          + Y_W'(c3) - (Y_W'(dc3) << 1) + Y_W'(ddc3);
        return $signed(t);
    endfunction

endpackage

// File: rtl/sp_efm_stage.sv
// One error-feedback accumulator with SP carry feedback.
// Ports: clk, rst_n (async, active-high), in (addend), r_o (residue), c_o (carry).
module sp_efm_stage
    import sp_mash_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int SP_A  = SP_A_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] r_o,
    output logic             c_o
);

    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [WIDTH:0]   w_sum;

    // The previous carry re-injects SP_A, shrinking the modulus to 2^WIDTH-SP_A.
    assign w_sum = {1'b0, in}
                 + {1'b0, r_res}
                 + (r_c ? (WIDTH+1)'(SP_A) : '0);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_res <= '0;
            r_c   <= 1'b0;
        end else begin
            r_res <= w_sum[WIDTH-1:0];
            r_c   <= w_sum[WIDTH];
        end
    end

    assign r_o = r_res;
    assign c_o = r_c;

endmodule

// File: rtl/sp_mash_111.sv
// Third-order SP-MASH 1-1-1 delta-sigma modulator for fractional-N control.
// Ports: clk, rst_n (async, active-high), x_i (fraction), y_o (signed -3..+4), e_o (stage-3 residue).
module sp_mash_111
    import sp_mash_pkg::*;
#(
    parameter int WIDTH   = 9,
    parameter int OUT_REG = 1,
    parameter int SP_A    = SP_A_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      x_i,
    output logic signed [Y_W-1:0] y_o,
    output logic [WIDTH-1:0]      e_o
);

    logic [WIDTH-1:0]      w_r1;
    logic [WIDTH-1:0]      w_r2;
    logic [WIDTH-1:0]      w_r3;
    logic                  w_c1;
    logic                  w_c2;
    logic                  w_c3;
    logic signed [Y_W-1:0] w_y;

    logic r_dc2;
    logic r_dc3;
    logic r_ddc3;

    // Each stage consumes the registered residue of the stage before it.
    sp_efm_stage #(.WIDTH(WIDTH), .SP_A(SP_A)) u_efm1 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (x_i),
        .r_o   (w_r1),
        .c_o   (w_c1)
    );

    sp_efm_stage #(.WIDTH(WIDTH), .SP_A(SP_A)) u_efm2 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (w_r1),
        .r_o   (w_r2),
        .c_o   (w_c2)
    );

    sp_efm_stage #(.WIDTH(WIDTH), .SP_A(SP_A)) u_efm3 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (w_r2),
        .r_o   (w_r3),
        .c_o   (w_c3)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_dc2  <= 1'b0;
            r_dc3  <= 1'b0;
            r_ddc3 <= 1'b0;
        end else begin
            r_dc2  <= w_c2;
            r_dc3  <= w_c3;
            r_ddc3 <= r_dc3;
        end
    end

    assign w_y = cancel_sum(w_c1, w_c2, r_dc2, w_c3, r_dc3, r_ddc3);

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic signed [Y_W-1:0] r_y;
            logic [WIDTH-1:0]      r_e;

            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    r_y <= '0;
                    r_e <= '0;
                end else begin
                    r_y <= w_y;
                    r_e <= w_r3;
                end
            end

            assign y_o = r_y;
            assign e_o = r_e;
        end else begin : g_comb
            assign y_o = w_y;
            assign e_o = w_r3;
        end
    endgenerate

endmodule

// File: tb/tb_sp_mash_111.sv
// Directed bench for sp_mash_111: registered and combinational output
// copies run side by side against hand vectors and a carry-level model.
module tb_sp_mash_111;

    localparam int W  = 9;
    localparam int SP = 1;
    localparam int M  = 1 << W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W-1:0]      x_i = '0;
    logic signed [3:0] y_r;
    logic signed [3:0] y_c;
    logic [W-1:0]      e_r;
    logic [W-1:0]      e_c;

    int n_chk = 0;
    int n_bad = 0;

    int m_r [3];
    int m_c [3];
    int m_d2, m_d3, m_dd3, m_y;

    int sum_y, nz, first_c1;
    int cap_y [1:64];
    int cap_e [1:64];

    // x=16 from reset, OUT_REG=0 view after updates 1..9 (worked by hand)
    int hv_y [1:9] = '{0, 0, 0, 0, 0, 0, 1, -2, 3};
    int hv_e [1:9] = '{0, 0, 16, 64, 160, 320, 48, 385, 321};

    sp_mash_111 #(.WIDTH(W), .OUT_REG(1), .SP_A(SP)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .x_i   (x_i),
        .y_o   (y_r),
        .e_o   (e_r)
    );

    sp_mash_111 #(.WIDTH(W), .OUT_REG(0), .SP_A(SP)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .x_i   (x_i),
        .y_o   (y_c),
        .e_o   (e_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_r[k] = 0;
            m_c[k] = 0;
        end
        m_d2 = 0; m_d3 = 0; m_dd3 = 0; m_y = 0;
    endtask

    task automatic m_step(input int x);
        int inp [3];
        int s [3];
        inp[0] = x; inp[1] = m_r[0]; inp[2] = m_r[1];
        for (int k = 0; k < 3; k++)
            s[k] = inp[k] + m_r[k] + SP * m_c[k];
        m_dd3 = m_d3;
        m_d3  = m_c[2];
        m_d2  = m_c[1];
        for (int k = 0; k < 3; k++) begin
            m_c[k] = (s[k] >= M) ? 1 : 0;
            m_r[k] = s[k] % M;
        end
        m_y = m_c[0] + m_c[1] - m_d2 + m_c[2] - 2 * m_d3 + m_dd3;
    endtask

    task automatic run_check(input string tag, input int x, input int n,
                             input bit cap);
        int ey, ee, el, er, py, pe, yv;
        ey = 0; ee = 0; el = 0; er = 0;
        m_reset();
        sum_y = 0; nz = 0; first_c1 = -1;
        py = int'(y_c);
        pe = int'(e_c);
        for (int i = 1; i <= n; i++) begin
            tick();
            m_step(x);
            yv = int'(y_c);
            if (yv != m_y) ey++;
            if (int'(e_c) != m_r[2]) ee++;
            if (int'(y_r) != py || int'(e_r) != pe) el++;
            if (yv < -3 || yv > 4) er++;
            if (int'(y_r) < -3 || int'(y_r) > 4) er++;
            sum_y += yv;
            if (yv != 0 || e_c != '0 || y_r != '0 || e_r != '0) nz++;
            if (first_c1 < 0 && dut_c.u_efm1.c_o) first_c1 = i;
            if (cap && i <= 64) begin
                cap_y[i] = yv;
                cap_e[i] = int'(e_c);
            end
            py = yv;
            pe = int'(e_c);
        end
        chk({tag, "_seq_y"}, ey, 0);
        chk({tag, "_seq_e"}, ee, 0);
        chk({tag, "_lat"}, el, 0);
        chk({tag, "_range"}, er, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        int err_y, err_e, dev;

        // reset held with a live input
        x_i = 9'd16;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_y_r", int'(y_r), 0);
            chk("rst_e_r", int'(e_r), 0);
            chk("rst_y_c", int'(y_c), 0);
            chk("rst_e_c", int'(e_c), 0);
        end

        // first updates against the hand vector
        rst_n = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("hand_y%0d", i), int'(y_c), hv_y[i]);
            chk($sformatf("hand_e%0d", i), int'(e_c), hv_e[i]);
        end
        chk("hand_yr9", int'(y_r), -2);

        // asynchronous clear between edges
        #2 rst_n = 1'b1;
        #1;
        chk("async_y_r", int'(y_r), 0);
        chk("async_e_r", int'(e_r), 0);
        chk("async_y_c", int'(y_c), 0);
        chk("async_e_c", int'(e_c), 0);
        tick();
        rst_n = 1'b0;

        // zero input stays silent
        x_i = 9'd0;
        do_reset();
        run_check("zero", 0, 1000, 1'b0);
        chk("zero_nz", nz, 0);

        // x=16 long run
        x_i = 9'd16;
        do_reset();
        run_check("x16", 16, 10000, 1'b1);
        chk("x16_first_c1", first_c1, 32);
        dev = sum_y * (M - SP) - 16 * 10000;
        if (dev < 0) dev = -dev;
        chk("x16_mean", (dev <= 5110) ? 1 : 0, 1);

        // full-scale input
        x_i = 9'd511;
        do_reset();
        run_check("x511", 511, 10000, 1'b0);
        dev = sum_y - 10000;
        if (dev < 0) dev = -dev;
        chk("x511_mean", (dev <= 10) ? 1 : 0, 1);

        // reset mid-run, then replay from zero
        x_i = 9'd16;
        do_reset();
        run_check("pre", 16, 500, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_y_c", int'(y_c), 0);
        tick();
        rst_n = 1'b0;
        err_y = 0;
        err_e = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (int'(y_c) != cap_y[i]) err_y++;
            if (int'(e_c) != cap_e[i]) err_e++;
        end
        chk("restart_y", err_y, 0);
        chk("restart_e", err_e, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
